// File: rtl/disp_sched_pkg.sv
// -----------------------------------------------------------------------------
// disp_sched_pkg
// Shared definitions for the display write scheduler:
//   - DEF_NUM_DIGITS / DEF_DIGIT_W : default geometry of one display update
//   - state_t                      : scheduler FSM states (IDLE, WRITE, DONE)
// -----------------------------------------------------------------------------
package disp_sched_pkg;

    localparam int DEF_NUM_DIGITS = 8;
    localparam int DEF_DIGIT_W    = 4;

    // IDLE  : waiting for a request, req_ready driven by the arbiter
    // WRITE : one digit written per cycle
    // DONE  : one-cycle completion pulse, last-grant pointer updated
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : disp_sched_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   req[1:0]  in   request vector, bit i from requester i
//   last      in   requester granted most recently (0 or 1)
//   gnt[1:0]  out  one-hot grant (all zero when nobody requests)
// On a tie the requester that was NOT granted last wins; a lone requester
// always wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        // Requester 0 wins when alone, or on a tie if requester 1 went last.
        if (req[0] && (!req[1] || last)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule : rr_arb2

// File: rtl/disp_write_sched.sv
// -----------------------------------------------------------------------------
// disp_write_sched
// Arbitrates two display-update requesters and streams the granted value into
// a display register file, one digit per clock.
//
// Parameters:
//   NUM_DIGITS  digits written per update
//   DIGIT_W     bits per digit
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   req_valid   in   [1:0] per-requester update request
//   req_data0   in   requester 0 value, digit k at [k*DIGIT_W +: DIGIT_W]
//   req_data1   in   requester 1 value, same layout
//   req_ready   out  [1:0] accept strobe (combinational, IDLE only)
//   num         out  digit value to the display write port (registered)
//   sel         out  digit index to the display write port (registered)
//   write       out  display write strobe (registered)
//   busy        out  high in WRITE and DONE
//   done        out  one-cycle pulse when an update completes
//   dbg_state   out  current FSM state, for observation only
//
// Handshake (valid/ready): a transfer from requester i happens on the rising
// edge where req_valid[i] and req_ready[i] are both high. req_ready is a
// combinational function of req_valid while IDLE and zero otherwise, so a
// requester must hold req_valid and its data stable until it sees req_ready;
// nothing is accepted while an update is in progress, but nothing is dropped.
//
// Timing for a handshake at cycle N: write high N+1 .. N+NUM_DIGITS with
// sel = 0 .. NUM_DIGITS-1, done at N+NUM_DIGITS+1, next accept N+NUM_DIGITS+2.
// -----------------------------------------------------------------------------
module disp_write_sched
    import disp_sched_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_W    = DEF_DIGIT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    req_valid,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] req_data0,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] req_data1,
    output logic [1:0]                    req_ready,
    output logic [DIGIT_W-1:0]            num,
    output logic [$clog2(NUM_DIGITS)-1:0] sel,
    output logic                          write,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    dbg_state
);

    localparam int SEL_W  = $clog2(NUM_DIGITS);
    localparam int DATA_W = NUM_DIGITS * DIGIT_W;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [SEL_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_data;
    logic                r_last;      // requester granted by the previous completed update
    logic                r_gnt_idx;   // requester owning the update in progress
    logic                r_write;
    logic                r_busy;
    logic                r_done;
    logic [DIGIT_W-1:0]  r_num;
    logic [SEL_W-1:0]    r_sel;

    // ------------------------------------------------------------------
    // Next-state / combinational signals
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_last_nxt;
    logic                w_gnt_idx_nxt;
    logic                w_write_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [DIGIT_W-1:0]  w_num_nxt;
    logic [SEL_W-1:0]    w_sel_nxt;

    logic [1:0]          w_gnt;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_req_data;
    logic [SEL_W-1:0]    w_cnt_inc;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (r_last),
        .gnt  (w_gnt)
    );

    // Ready only while idle and out of reset; the arbiter already masks it
    // with req_valid, so at most one bit is high and only for a valid requester.
    assign req_ready  = (r_state == IDLE && !reset) ? w_gnt : 2'b00;
    assign w_xfer     = |(req_valid & req_ready);
    assign w_req_data = w_gnt[1] ? req_data1 : req_data0;
    assign w_cnt_inc  = r_cnt + SEL_W'(1);

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_data_nxt    = r_data;
        w_last_nxt    = r_last;
        w_gnt_idx_nxt = r_gnt_idx;
        w_write_nxt   = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_num_nxt     = '0;
        w_sel_nxt     = '0;

        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt   = WRITE;
                    w_data_nxt    = w_req_data;
                    w_gnt_idx_nxt = w_gnt[1];
                    w_cnt_nxt     = '0;
                    // Digit 0 is taken straight from the request so the first
                    // write appears on the cycle right after the handshake.
                    w_write_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_sel_nxt     = '0;
                    w_num_nxt     = w_req_data[DIGIT_W-1:0];
                end
            end

            WRITE: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == LAST_SEL) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    // Outputs are registered, so the values for the next
                    // write cycle are prepared from the incremented count.
                    w_cnt_nxt   = w_cnt_inc;
                    w_write_nxt = 1'b1;
                    w_sel_nxt   = w_cnt_inc;
                    w_num_nxt   = r_data[int'(w_cnt_inc)*DIGIT_W +: DIGIT_W];
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                // Pointer moves only on completion, so an aborted update
                // does not change who wins the next tie.
                w_last_nxt  = r_gnt_idx;
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_last    <= 1'b1;  // requester 0 wins the first tie
            r_gnt_idx <= 1'b0;
            r_write   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_num     <= '0;
            r_sel     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_data    <= w_data_nxt;
            r_last    <= w_last_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_write   <= w_write_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_num     <= w_num_nxt;
            r_sel     <= w_sel_nxt;
        end
    end

    assign write     = r_write;
    assign busy      = r_busy;
    assign done      = r_done;
    assign num       = r_num;
    assign sel       = r_sel;
    assign dbg_state = r_state;

endmodule : disp_write_sched

// File: doc/disp_write_sched.md
DISP_WRITE_SCHED -- requirements
Module: disp_write_sched

Interface
REQ-001 The block SHALL expose parameter NUM_DIGITS, default 8, number of display digits written per update.
REQ-002 The block SHALL expose parameter DIGIT_W, default 4, bits per digit value.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  2  per-requester update request; bit i belongs to requester i.
REQ-006 Port req_data0  input  NUM_DIGITS*DIGIT_W  requester 0 display value; digit k at bits [4k+3:4k].
REQ-007 Port req_data1  input  NUM_DIGITS*DIGIT_W  requester 1 display value, same layout.
REQ-008 Port req_ready  output  2  grant/accept strobe; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 Port num  output  DIGIT_W  digit value to the display register-file write port.
REQ-010 Port sel  output  $clog2(NUM_DIGITS)  digit index to the display write port.
REQ-011 Port write  output  1  write strobe to the display write port.
REQ-012 Port busy  output  1  high while an update sequence is in progress.
REQ-013 Port done  output  1  one-cycle pulse on completion of an update.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WRITE and DONE.
REQ-015 In IDLE, req_ready SHALL be combinational, with at most one bit high, and only for a requester whose req_valid is high.
REQ-016 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last; if only one is valid, grant it.
REQ-017 On a transfer, the block SHALL capture the granted data into an internal register, clear the digit counter, and enter WRITE on the next edge.
REQ-018 In WRITE, write SHALL be 1, sel SHALL be the digit counter, and num SHALL be captured digit[counter]; all three SHALL be registered outputs.
REQ-019 The counter SHALL increment by 1 per cycle in WRITE; write SHALL therefore be high for exactly NUM_DIGITS consecutive cycles with sel = 0,1,...,NUM_DIGITS-1.
REQ-020 After the cycle with sel = NUM_DIGITS-1, the FSM SHALL enter DONE with write = 0.
REQ-021 In DONE, done SHALL be 1 for one cycle, the last-grant pointer SHALL be updated, and the FSM SHALL return to IDLE.
REQ-022 Timing: handshake at cycle N, first write at N+1, last write at N+NUM_DIGITS, done at N+NUM_DIGITS+1, earliest next handshake at N+NUM_DIGITS+2.
REQ-023 busy SHALL be 1 in WRITE and DONE and 0 in IDLE.
REQ-024 req_ready SHALL be 0 in WRITE and DONE; requests arriving then SHALL be held by the requester and not lost.
REQ-025 Changes to req_data or req_valid after capture SHALL NOT affect the sequence in progress.
REQ-026 Outside WRITE, num and sel SHALL hold 0.
REQ-027 If both requesters are valid continuously, grants SHALL alternate 0,1,0,1...

Reset
REQ-028 While reset is high at a clock edge, the FSM SHALL go to IDLE, the counter SHALL go to 0, and write, busy, done, num and sel SHALL go to 0.
REQ-029 req_ready SHALL be 0 while reset is high.
REQ-030 After reset, the last-grant pointer SHALL be 1, so requester 0 wins the first tie.
REQ-031 A reset during WRITE SHALL abort the sequence with no further writes and no done pulse; the partially written display is acceptable.

Structure
REQ-032 Package disp_sched_pkg SHALL hold the state enum and the default NUM_DIGITS and DIGIT_W constants.
REQ-033 The two-way round-robin grant logic SHALL be a sub-module rr_arb2 with inputs req[1:0] and last[0] and output one-hot gnt[1:0].

Verification
REQ-034 Reset, then a single request: hold reset 10 cycles, then req_valid=01 with req_data0=32'h76543210 -> write high 8 cycles, sel 0..7, num 0..7, then done one cycle.
REQ-035 Tie after reset: req_valid=11 with data0=32'h11111111 and data1=32'h22222222 -> requester 0 written first (num=1); requester 1 is ready 10 cycles later (num=2).
REQ-036 Continuous contention over 4 updates -> grant order 0,1,0,1, and each update has exactly 8 writes.
REQ-037 Request arriving mid-sequence: req_valid[1] rises at the 3rd write cycle -> req_ready[1]=0 until IDLE, then accepted at N+10.
REQ-038 Reset asserted at the 4th write cycle -> write=0 on the next edge, no done pulse, busy=0, and a new request is accepted normally.
REQ-039 Data change after capture: req_data0 changes to 32'hFFFFFFFF the cycle after handshake -> the written values still match the captured data.
